draw_board: RTL
===============

Name: draw_board

Overview:
- Pixel-pipeline stage between draw_background and draw_rect.
- Holds the playfield of locked pieces as a 10-column x 20-row array of 3-bit colour codes; code 0 means empty.
- Paints occupied cells over the incoming background pixel.
- Accepts single-cell writes when a falling piece locks, performs row-clear shift-down on request, and reports which rows are full.

Parameters:
- BOARD_X, 480, hcount of the board's left edge.
- BOARD_Y, 40, vcount of the board's top edge.
- CELL_LOG2, 5, log2 of the cell size in pixels (32x32 cells; board is 320x640).

Ports:
- pclk  in  1  pixel clock (75 MHz).
- rst  in  1  synchronous active-high reset.
- hcount_in  in  11  horizontal pixel counter.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- vcount_in  in  11  vertical line counter.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- rgb_in  in  12  background pixel {r,g,b}.
- wr_en  in  1  write one cell this cycle.
- wr_row  in  5  row of the cell to write, 0 = top.
- wr_col  in  4  column of the cell to write, 0 = left.
- wr_color  in  3  colour code to store; 0 erases the cell.
- clr_req  in  1  request removal of row clr_row.
- clr_row  in  5  row to remove.
- busy  out  1  row-clear shift in progress.
- rows_full  out  20  bit r set when all 10 cells of row r are nonzero.
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  timing bus delayed by 2 cycles.
- rgb_out  out  12  composed pixel.

Behaviour:
- Clock and reset: one clock, pclk; reset is synchronous and active-high on rst.
- Reset: all 200 cells = 0; busy = 0; rows_full = 0; all timing outputs = 0; rgb_out = 12'h000.
- Pixel latency is exactly 2 cycles. Every timing output equals its input delayed by 2 cycles, unaltered.
- Stage 1 registers:
  - in_board = (hcount >= BOARD_X) and (hcount < BOARD_X+320) and (vcount >= BOARD_Y) and (vcount < BOARD_Y+640).
  - col = (hcount-BOARD_X)>>CELL_LOG2 and row = (vcount-BOARD_Y)>>CELL_LOG2. Use 11-bit subtraction; results are valid only when in_board.
  - edge = x or y offset within the cell equals 0 or 31.
  - Delayed rgb_in and the delayed timing bus.
- Stage 2 pixel selection:
  - Delayed hblnk or vblnk set → rgb_out = 12'h000.
  - Otherwise in_board and cell[row][col] != 0 → edge ? 12'h111 : PALETTE[code].
  - Otherwise → delayed rgb_in.
- Cell lookup reads board state as of the stage-1 cycle. A write in the same cycle is visible from the next pixel onward.
- Write port: when wr_en=1, busy=0, wr_row<20, wr_col<10 and no accepted clr_req in the same cycle, the cell takes wr_color at the next edge. All other writes are silently dropped.
- Row-clear state machine:
  - IDLE: on clr_req=1 with clr_row<20, latch idx = clr_row and go to SHIFT. busy=1 from the next cycle. clr_req with clr_row>=20 is ignored.
  - SHIFT, each cycle: if idx > 0, row[idx] <= row[idx-1] and idx decrements. If idx == 0, row[0] <= all zero and return to IDLE.
  - busy is high for clr_row+1 cycles.
  - clr_req while busy is ignored; the requester must wait for busy=0.
  - Simultaneous wr_en and clr_req in IDLE: the clear wins and the write is dropped.
  - Mid-frame shifts may tear one frame; this is accepted.
- rows_full is registered from the current board each cycle, so it lags the board by 1 cycle. It is valid during busy but transient.
- rst asserted during SHIFT aborts the clear: board zeroed, IDLE, busy = 0 the next cycle.

Decomposition:
- Package board_pkg:
  - BOARD_COLS=10, BOARD_ROWS=20, CELL_EDGE_RGB=12'h111.
  - PALETTE[1..7]: 1=12'h0FF, 2=12'hFF0, 3=12'hF0F, 4=12'hF80, 5=12'h00F, 6=12'h0F0, 7=12'hF00.
  - SHIFT FSM state encoding {IDLE, SHIFT}.
- One natural sub-module: board_mem. It holds the cell array, write port, shift FSM, busy and rows_full, and provides a combinational read of cell[row][col]. The top level is the 2-stage pixel pipeline.

Test Plan:
- Reset then 1 frame at 1280x720: every rgb_out equals rgb_in delayed by 2 cycles (or 0 in blank); timing outputs are the inputs delayed by 2; busy=0; rows_full=0.
- wr_en with row 0, col 0, colour 3: pixel (BOARD_X+5, BOARD_Y+5) → 12'hF0F; pixel (BOARD_X, BOARD_Y) → 12'h111; pixel (BOARD_X+32, BOARD_Y+5) → background.
- Write colour 1 into all 10 columns of row 19 → rows_full = 20'h80000 one cycle after the last write; write colour 0 to col 4 → bit clears.
- Fill row 18 (colour 2) and row 19 (colour 5), then clr_req with clr_row=19 → busy high exactly 20 cycles; afterward row 19 holds colour 2, rows 0-18 are empty, rows_full = 20'h80000.
- During busy, wr_en at row 0 and a second clr_req → both ignored; board unchanged apart from the shift; busy still deasserts on schedule.
- Out-of-range write (wr_col=10 or wr_row=20) and clr_row=25 → no state change, busy stays 0. Assert rst mid-SHIFT → board empty and busy=0 the next cycle.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants, types and colour palette for the draw_board playfield stage.
// The board is BOARD_ROWS x BOARD_COLS cells of 3-bit colour codes, code 0 = empty.
package board_pkg;

    localparam int          BOARD_COLS    = 10;
    localparam int          BOARD_ROWS    = 20;
    localparam logic [11:0] CELL_EDGE_RGB = 12'h111;

    typedef logic [BOARD_COLS-1:0][2:0] board_row_t;
    typedef board_row_t [BOARD_ROWS-1:0] board_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } shift_state_e;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
    } timing_t;

    function automatic logic [11:0] palette(input logic [2:0] code);
        logic [11:0] rgb;
        case (code)
            3'd1:    rgb = 12'h0FF;
            3'd2:    rgb = 12'hFF0;
            3'd3:    rgb = 12'hF0F;
            3'd4:    rgb = 12'hF80;
            3'd5:    rgb = 12'h00F;
            3'd6:    rgb = 12'h0F0;
            3'd7:    rgb = 12'hF00;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/board_mem.sv
// Playfield storage: single-cell write port, row-clear shift-down FSM,
// registered full-row flags and a combinational cell read for the pixel pipeline.
module board_mem
    import board_pkg::*;
(
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [4:0]            wr_row,
    input  logic [3:0]            wr_col,
    input  logic [2:0]            wr_color,
    input  logic                  clr_req,
    input  logic [4:0]            clr_row,
    input  logic [4:0]            rd_row,
    input  logic [3:0]            rd_col,
    output logic [2:0]            rd_code,
    output logic                  busy,
    output logic [BOARD_ROWS-1:0] rows_full
);

    localparam logic [4:0] ROW_LIMIT = 5'(BOARD_ROWS);
    localparam logic [3:0] COL_LIMIT = 4'(BOARD_COLS);

    board_t                cells_q, cells_d;
    shift_state_e          state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [BOARD_ROWS-1:0] rows_full_q, rows_full_d;
    logic                  clr_accept;
    logic                  wr_accept;

    // A clear request takes priority over a write in the same cycle.
    always_comb begin
        clr_accept = (state_q == IDLE) && clr_req && (clr_row < ROW_LIMIT);
        wr_accept  = (state_q == IDLE) && wr_en && (wr_row < ROW_LIMIT)
                     && (wr_col < COL_LIMIT) && !clr_accept;
    end

    always_comb begin
        cells_d = cells_q;
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_accept) begin
                    state_d = SHIFT;
                    idx_d   = clr_row;
                end
            end
            SHIFT: begin
                if (idx_q != 5'd0) begin
                    cells_d[idx_q] = cells_q[idx_q - 5'd1];
                    idx_d          = idx_q - 5'd1;
                end else begin
                    cells_d[0] = '0;
                    state_d    = IDLE;
                end
            end
        endcase
        if (wr_accept) begin
            cells_d[wr_row][wr_col] = wr_color;
        end
    end

    always_comb begin
        for (int r = 0; r < BOARD_ROWS; r++) begin
            rows_full_d[r] = 1'b1;
            for (int c = 0; c < BOARD_COLS; c++) begin
                if (cells_q[r][c] == 3'd0) begin
                    rows_full_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            cells_q     <= '0;
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            rows_full_q <= '0;
        end else begin
            cells_q     <= cells_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            rows_full_q <= rows_full_d;
        end
    end

    // Off-board coordinates read as empty so the caller never indexes past the array.
    always_comb begin
        if ((rd_row < ROW_LIMIT) && (rd_col < COL_LIMIT)) begin
            rd_code = cells_q[rd_row][rd_col];
        end else begin
            rd_code = 3'd0;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign rows_full = rows_full_q;

endmodule

// File: rtl/draw_board.sv
// Two-stage pixel pipeline that paints locked playfield cells over the background.
// Stage 1 decodes the pixel position and reads the cell; stage 2 selects the output colour.
module draw_board
    import board_pkg::*;
#(
    parameter int BOARD_X   = 480,
    parameter int BOARD_Y   = 40,
    parameter int CELL_LOG2 = 5
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [10:0]           hcount_in,
    input  logic                  hsync_in,
    input  logic                  hblnk_in,
    input  logic [10:0]           vcount_in,
    input  logic                  vsync_in,
    input  logic                  vblnk_in,
    input  logic [11:0]           rgb_in,
    input  logic                  wr_en,
    input  logic [4:0]            wr_row,
    input  logic [3:0]            wr_col,
    input  logic [2:0]            wr_color,
    input  logic                  clr_req,
    input  logic [4:0]            clr_row,
    output logic                  busy,
    output logic [BOARD_ROWS-1:0] rows_full,
    output logic [10:0]           hcount_out,
    output logic                  hsync_out,
    output logic                  hblnk_out,
    output logic [10:0]           vcount_out,
    output logic                  vsync_out,
    output logic                  vblnk_out,
    output logic [11:0]           rgb_out
);

    localparam int          CELL_PX   = 1 << CELL_LOG2;
    localparam logic [10:0] X_START   = 11'(BOARD_X);
    localparam logic [10:0] X_END     = 11'(BOARD_X + BOARD_COLS * CELL_PX);
    localparam logic [10:0] Y_START   = 11'(BOARD_Y);
    localparam logic [10:0] Y_END     = 11'(BOARD_Y + BOARD_ROWS * CELL_PX);
    localparam logic [10:0] CELL_MASK = 11'(CELL_PX - 1);

    logic [10:0] x_off, y_off;
    logic [10:0] x_in_cell, y_in_cell;
    logic [4:0]  rd_row;
    logic [3:0]  rd_col;
    logic [2:0]  rd_code;
    logic        in_board;

    timing_t     t1_d, t1_q;
    timing_t     t2_d, t2_q;
    logic [2:0]  code_d, code_q;
    logic        cell_edge_d, cell_edge_q;
    logic [11:0] rgb1_d, rgb1_q;
    logic [11:0] rgb_out_d, rgb_out_q;

    board_mem u_board_mem (
        .pclk      (pclk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_color  (wr_color),
        .clr_req   (clr_req),
        .clr_row   (clr_row),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_code   (rd_code),
        .busy      (busy),
        .rows_full (rows_full)
    );

    // Offsets wrap below the board edge; in_board masks those results out.
    always_comb begin
        x_off     = hcount_in - X_START;
        y_off     = vcount_in - Y_START;
        x_in_cell = x_off & CELL_MASK;
        y_in_cell = y_off & CELL_MASK;
        rd_col    = 4'(x_off >> CELL_LOG2);
        rd_row    = 5'(y_off >> CELL_LOG2);
        in_board  = (hcount_in >= X_START) && (hcount_in < X_END)
                    && (vcount_in >= Y_START) && (vcount_in < Y_END);
    end

    always_comb begin
        t1_d        = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
        rgb1_d      = rgb_in;
        code_d      = in_board ? rd_code : 3'd0;
        cell_edge_d = (x_in_cell == 11'd0) || (x_in_cell == CELL_MASK)
                      || (y_in_cell == 11'd0) || (y_in_cell == CELL_MASK);
    end

    always_comb begin
        t2_d = t1_q;
        if (t1_q.hblnk || t1_q.vblnk) begin
            rgb_out_d = 12'h000;
        end else if (code_q != 3'd0) begin
            rgb_out_d = cell_edge_q ? CELL_EDGE_RGB : palette(code_q);
        end else begin
            rgb_out_d = rgb1_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            t1_q        <= '0;
            t2_q        <= '0;
            code_q      <= 3'd0;
            cell_edge_q <= 1'b0;
            rgb1_q      <= 12'h000;
            rgb_out_q   <= 12'h000;
        end else begin
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            code_q      <= code_d;
            cell_edge_q <= cell_edge_d;
            rgb1_q      <= rgb1_d;
            rgb_out_q   <= rgb_out_d;
        end
    end

    assign hcount_out = t2_q.hcount;
    assign hsync_out  = t2_q.hsync;
    assign hblnk_out  = t2_q.hblnk;
    assign vcount_out = t2_q.vcount;
    assign vsync_out  = t2_q.vsync;
    assign vblnk_out  = t2_q.vblnk;
    assign rgb_out    = rgb_out_q;

endmodule
